counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the shared interval counter and of each length input.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester interval request, level-sensitive; requester holds it high until its done pulse.
REQ-005 len0  input  WIDTH  requester 0 interval length L; 0 encodes 2^WIDTH.
REQ-006 len1  input  WIDTH  requester 1 interval length L; 0 encodes 2^WIDTH.
REQ-007 gnt  output  2  one-hot grant; at most one bit set.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 count  output  WIDTH  current value of the shared up-counter.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; every transition occurs on a rising clk edge.
REQ-012 Round-robin pointer pri (1 bit) SHALL select the priority requester when both req bits are high.
REQ-013 IDLE with req==0: SHALL remain in IDLE, gnt=0, done=0, count=0.
REQ-014 IDLE with exactly one req bit high: SHALL grant that requester; both high: SHALL grant requester pri.
REQ-015 On the grant edge: state=RUN, gnt bit set, count=0, L latched from the granted requester's len input.
REQ-016 len inputs SHALL be ignored outside the grant edge; changes during RUN or DONE have no effect.
REQ-017 RUN, granted req still high, count != (L-1) mod 2^WIDTH: count SHALL increment by 1 per cycle.
REQ-018 RUN, granted req still high, count == (L-1) mod 2^WIDTH: next state DONE, count holds, done bit of granted requester =1 for exactly that DONE cycle.
REQ-019 RUN therefore spans exactly L cycles with count values 0..L-1; L=0 spans 2^WIDTH cycles (0..2^WIDTH-1, no wrap to 0 before DONE).
REQ-020 Abort: granted req low at any RUN edge SHALL go to IDLE next cycle, gnt=0, count=0, no done pulse; abort takes priority over terminal count.
REQ-021 DONE SHALL always go to IDLE after one cycle, gnt held through DONE, req ignored in DONE.
REQ-022 On leaving RUN via abort or leaving DONE, pri SHALL become the index of the requester not just served.
REQ-023 At least one IDLE cycle SHALL separate consecutive grants.
REQ-024 The non-granted req bit SHALL have no effect while busy.

Reset
REQ-025 rst high at an edge SHALL force, regardless of state: state=IDLE, pri=0, gnt=0, done=0, busy=0, count=0, latched L=0.
REQ-026 rst SHALL take priority over all other inputs, including mid-RUN and during DONE.

Verification
REQ-027 Reset, then req=01, len0=3 -> grant edge: gnt=01, busy=1; count 0,1,2; next cycle done=01 with count=2; following cycle gnt=00, busy=0, count=0.
REQ-028 Reset, req=11 same edge, len0=2, len1=5 -> requester 0 served first (count 0,1, done=01), one IDLE cycle, then gnt=10, count 0..4, done=10, pri ends 0.
REQ-029 req=10, len1=0 (WIDTH=4) -> count 0..15 over 16 RUN cycles, then done=10 with count=15.
REQ-030 req=01, len0=6, drop req[0] when count=1 -> next cycle IDLE, gnt=00, count=0, no done; then req=11 -> gnt=10 (pri=1).
REQ-031 req=01, len0=8, rst asserted when count=2 -> next edge gnt=00, done=00, busy=0, count=0; then req=11 -> gnt=01 (pri=0).
REQ-032 req=01, len0=4, len0 changed to 1 at count=0 -> RUN still spans 4 cycles (count 0..3) before done=01.

Source files
------------

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that grants a shared up-counter for a
// latched interval length, pulsing done to the winner when the interval expires.
module counter_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] len0_i,
  input  logic [WIDTH-1:0] len1_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             pri_q, pri_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             sel;
  logic             served;
  logic [WIDTH-1:0] last_count;

  assign sel        = (req_i == 2'b11) ? pri_q : req_i[1];
  assign served     = gnt_q[1];
  // Length 0 wraps to all-ones here, giving a full 2^WIDTH-cycle interval.
  assign last_count = len_q - WIDTH'(1);

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    gnt_d   = gnt_q;
    count_d = count_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          state_d = StRun;
          gnt_d   = {sel, ~sel};
          count_d = '0;
          len_d   = sel ? len1_i : len0_i;
        end
      end
      StRun: begin
        // Abort wins over terminal count.
        if ((req_i & gnt_q) == 2'b00) begin
          state_d = StIdle;
          gnt_d   = 2'b00;
          count_d = '0;
          pri_d   = ~served;
        end else if (count_q == last_count) begin
          state_d = StDone;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
        count_d = '0;
        pri_d   = ~served;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pri_q   <= 1'b0;
      gnt_q   <= 2'b00;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone) ? gnt_q : 2'b00;
  assign count_o = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed scoreboard bench: each stimulus step queues the outputs expected
// after its clock edge; an independent monitor pops and compares at negedge.
module tb_counter_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       gnt;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH-1:0] count;

  typedef struct {
    int         id;
    logic [8:0] v;  // {gnt, busy, done, count}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   step_id = 0;

  counter_arbiter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .len0_i (len0),
    .len1_i (len1),
    .gnt_o  (gnt),
    .busy_o (busy),
    .done_o (done),
    .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Apply inputs, clock once, then queue the outputs expected after that edge.
  task automatic step(input logic r, input logic [1:0] rq, input logic [3:0] l0,
                      input logic [3:0] l1, input logic [1:0] eg, input logic eb,
                      input logic [1:0] ed, input logic [3:0] ec);
    exp_t e;
    rst  = r;
    req  = rq;
    len0 = l0;
    len1 = l1;
    @(posedge clk);
    #1;
    e.id = step_id;
    e.v  = {eg, eb, ed, ec};
    exp_q.push_back(e);
    step_id++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {gnt, busy, done, count};
      n_cmp++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL step%0d: got gnt=%b busy=%b done=%b count=%0d, required gnt=%b busy=%b done=%b count=%0d",
                 e.id, act[8:7], act[6], act[5:4], act[3:0],
                 e.v[8:7], e.v[6], e.v[5:4], e.v[3:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;

    // Single requester, L=3.
    step(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b01, 3, 0, 2'b01, 1, 2'b00, 0);
    step(0, 2'b01, 3, 0, 2'b01, 1, 2'b00, 1);
    step(0, 2'b01, 3, 0, 2'b01, 1, 2'b00, 2);
    step(0, 2'b01, 3, 0, 2'b01, 1, 2'b01, 2);
    step(0, 2'b00, 3, 0, 2'b00, 0, 2'b00, 0);

    // Simultaneous requests: 0 first, idle gap, then 1; pri returns to 0.
    step(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b11, 2, 5, 2'b01, 1, 2'b00, 0);
    step(0, 2'b11, 2, 5, 2'b01, 1, 2'b00, 1);
    step(0, 2'b11, 2, 5, 2'b01, 1, 2'b01, 1);
    step(0, 2'b11, 2, 5, 2'b00, 0, 2'b00, 0);
    step(0, 2'b11, 2, 5, 2'b10, 1, 2'b00, 0);
    for (int k = 1; k <= 4; k++) step(0, 2'b11, 2, 5, 2'b10, 1, 2'b00, 4'(k));
    step(0, 2'b11, 2, 5, 2'b10, 1, 2'b10, 4);
    step(0, 2'b00, 2, 5, 2'b00, 0, 2'b00, 0);
    step(0, 2'b11, 1, 1, 2'b01, 1, 2'b00, 0);
    step(0, 2'b11, 1, 1, 2'b01, 1, 2'b01, 0);
    step(0, 2'b00, 1, 1, 2'b00, 0, 2'b00, 0);

    // L=0 on requester 1: full 16-cycle run; req[0] toggling is ignored.
    step(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b10, 0, 0, 2'b10, 1, 2'b00, 0);
    for (int k = 1; k <= 15; k++) step(0, (k % 2) ? 2'b11 : 2'b10, 0, 0, 2'b10, 1, 2'b00, 4'(k));
    step(0, 2'b11, 0, 0, 2'b10, 1, 2'b10, 15);
    step(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);

    // Abort at count=1, then pri=1 grants requester 1.
    step(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b01, 6, 0, 2'b01, 1, 2'b00, 0);
    step(0, 2'b01, 6, 0, 2'b01, 1, 2'b00, 1);
    step(0, 2'b00, 6, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b11, 6, 3, 2'b10, 1, 2'b00, 0);
    step(0, 2'b00, 6, 3, 2'b00, 0, 2'b00, 0);

    // Abort on the terminal-count edge: no done pulse.
    step(0, 2'b01, 2, 0, 2'b01, 1, 2'b00, 0);
    step(0, 2'b01, 2, 0, 2'b01, 1, 2'b00, 1);
    step(0, 2'b00, 2, 0, 2'b00, 0, 2'b00, 0);

    // Reset mid-RUN, then pri=0 grants requester 0.
    step(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b01, 8, 0, 2'b01, 1, 2'b00, 0);
    step(0, 2'b01, 8, 0, 2'b01, 1, 2'b00, 1);
    step(0, 2'b01, 8, 0, 2'b01, 1, 2'b00, 2);
    step(1, 2'b01, 8, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b11, 8, 8, 2'b01, 1, 2'b00, 0);

    // Reset during DONE clears pri (otherwise requester 1 would win next).
    step(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b01, 1, 0, 2'b01, 1, 2'b00, 0);
    step(0, 2'b01, 1, 0, 2'b01, 1, 2'b01, 0);
    step(1, 2'b01, 1, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b11, 1, 1, 2'b01, 1, 2'b00, 0);
    step(0, 2'b11, 1, 1, 2'b01, 1, 2'b01, 0);
    step(0, 2'b00, 1, 1, 2'b00, 0, 2'b00, 0);

    // len0 changed after the grant edge has no effect.
    step(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    step(0, 2'b01, 4, 0, 2'b01, 1, 2'b00, 0);
    step(0, 2'b01, 1, 0, 2'b01, 1, 2'b00, 1);
    step(0, 2'b01, 1, 0, 2'b01, 1, 2'b00, 2);
    step(0, 2'b01, 1, 0, 2'b01, 1, 2'b00, 3);
    step(0, 2'b01, 1, 0, 2'b01, 1, 2'b01, 3);
    step(0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
